// File: rtl/sc_life_manager.sv
// ---------------------------------------------------------------------------
// sc_life_manager
// Lives tracker for the Frogger datapath. It handles lose/gain requests,
// saturates gains at MAX_LIVES, opens an invulnerability (grace) window after
// each lost life, and holds a sticky GAMEOVER state until clear or reset.
//
// Optional build macro: SC_LIFEMANAGER_EDGE_DETECT_EN
//   When defined, lose/gain only fire on a falling edge of the active-low
//   input. This adds one register stage ahead of the decode logic.
//
// Ports:
//   SC_LIFEMANAGER_CLOCK_50      in   system clock, rising edge
//   SC_LIFEMANAGER_RESET_InLow   in   synchronous active-low reset
//   SC_LIFEMANAGER_lose_InLow    in   active-low lose-one-life request
//   SC_LIFEMANAGER_gain_InLow    in   active-low gain-one-life request
//   SC_LIFEMANAGER_CLEAR_InLow   in   active-low synchronous game restart
//   SC_LIFEMANAGER_data_OutBUS   out  current lives (registered)
//   SC_LIFEMANAGER_grace_Out     out  high while in GRACE
//   SC_LIFEMANAGER_gameover_Out  out  high while in GAMEOVER
//   SC_LIFEMANAGER_lifelost_Out  out  one-cycle pulse per accepted lose
// ---------------------------------------------------------------------------
module sc_life_manager #(
    parameter int LIFE_DATAWIDTH = 8,
    parameter int INIT_LIVES     = 3,
    parameter int MAX_LIVES      = 9,
    parameter int GRACE_CYCLES   = 50000000,
    parameter int GRACE_WIDTH    = 26
) (
    input  logic                      SC_LIFEMANAGER_CLOCK_50,
    input  logic                      SC_LIFEMANAGER_RESET_InLow,
    input  logic                      SC_LIFEMANAGER_lose_InLow,
    input  logic                      SC_LIFEMANAGER_gain_InLow,
    input  logic                      SC_LIFEMANAGER_CLEAR_InLow,
    output logic [LIFE_DATAWIDTH-1:0] SC_LIFEMANAGER_data_OutBUS,
    output logic                      SC_LIFEMANAGER_grace_Out,
    output logic                      SC_LIFEMANAGER_gameover_Out,
    output logic                      SC_LIFEMANAGER_lifelost_Out
);

    typedef enum logic [1:0] {
        ALIVE    = 2'b00,
        GRACE    = 2'b01,
        GAMEOVER = 2'b10
    } state_t;

    localparam logic [LIFE_DATAWIDTH-1:0] INIT_L = LIFE_DATAWIDTH'(INIT_LIVES);
    localparam logic [LIFE_DATAWIDTH-1:0] MAX_L  = LIFE_DATAWIDTH'(MAX_LIVES);
    localparam logic [LIFE_DATAWIDTH-1:0] ONE_L  = LIFE_DATAWIDTH'(1);
    // Timer is loaded with N-1 and the exit happens on the edge where it
    // reads 0, giving a window of exactly GRACE_CYCLES cycles.
    localparam logic [GRACE_WIDTH-1:0] GRACE_LOAD =
        (GRACE_CYCLES > 0) ? GRACE_WIDTH'(GRACE_CYCLES - 1) : '0;

    state_t                    state;
    logic [GRACE_WIDTH-1:0]    timer;
    logic [LIFE_DATAWIDTH-1:0] count;
    logic                      lose_req;
    logic                      gain_req;
    logic [LIFE_DATAWIDTH-1:0] count_inc;

    wire clk = SC_LIFEMANAGER_CLOCK_50;
    wire rst = ~SC_LIFEMANAGER_RESET_InLow;
    wire clr = ~SC_LIFEMANAGER_CLEAR_InLow;

`ifdef SC_LIFEMANAGER_EDGE_DETECT_EN
    // Stage 1 samples the pin, stage 2 holds the previous sample; a request
    // is a 1->0 transition between them, so a held-low pin fires once.
    logic lose_q, lose_qq, gain_q, gain_qq;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lose_q  <= 1'b1;
            lose_qq <= 1'b1;
            gain_q  <= 1'b1;
            gain_qq <= 1'b1;
        end else begin
            lose_q  <= SC_LIFEMANAGER_lose_InLow;
            lose_qq <= lose_q;
            gain_q  <= SC_LIFEMANAGER_gain_InLow;
            gain_qq <= gain_q;
        end
    end

    assign lose_req = lose_qq & ~lose_q;
    assign gain_req = gain_qq & ~gain_q;
`else
    assign lose_req = ~SC_LIFEMANAGER_lose_InLow;
    assign gain_req = ~SC_LIFEMANAGER_gain_InLow;
`endif

    // Saturating increment; never wraps.
    assign count_inc = (count >= MAX_L) ? MAX_L : count + ONE_L;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state    <= ALIVE;
            timer    <= '0;
            count    <= INIT_L;
            SC_LIFEMANAGER_grace_Out    <= 1'b0;
            SC_LIFEMANAGER_gameover_Out <= 1'b0;
            SC_LIFEMANAGER_lifelost_Out <= 1'b0;
        end else begin
            SC_LIFEMANAGER_lifelost_Out <= 1'b0;
            case (state)
                ALIVE: begin
                    if (lose_req) begin
                        SC_LIFEMANAGER_lifelost_Out <= 1'b1;
                        if (count > ONE_L) begin
                            count <= count - ONE_L;
                            if (GRACE_CYCLES > 0) begin
                                state <= GRACE;
                                timer <= GRACE_LOAD;
                                SC_LIFEMANAGER_grace_Out <= 1'b1;
                            end
                        end else begin
                            count <= '0;
                            state <= GAMEOVER;
                            SC_LIFEMANAGER_gameover_Out <= 1'b1;
                        end
                    end else if (gain_req) begin
                        count <= count_inc;
                    end
                end
                GRACE: begin
                    // Lose is masked here; gain still counts.
                    if (gain_req) count <= count_inc;
                    if (timer == '0) begin
                        state <= ALIVE;
                        SC_LIFEMANAGER_grace_Out <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAMEOVER: begin
                    count <= '0;
                end
                default: begin
                    state <= ALIVE;
                    SC_LIFEMANAGER_grace_Out    <= 1'b0;
                    SC_LIFEMANAGER_gameover_Out <= 1'b0;
                end
            endcase
        end
    end

    assign SC_LIFEMANAGER_data_OutBUS = count;

endmodule
